// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute
// phases, plus combinational ALU-operation decode and PC write enable.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       ZERO,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic       pc_cntrl_out,
  output logic       IR_write,
  output logic       reg_dst,
  output logic       jal_reg,
  output logic       pc_to_reg,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_A,
  output logic [1:0] alu_src_B,
  output logic [1:0] pc_src,
  output logic       I_or_D,
  output logic       mem_write,
  output logic       mem_read,
  output logic [2:0] alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF          = 4'b0000,
    S_ID          = 4'b0001,
    S_BRANCH      = 4'b0010,
    S_JUMP        = 4'b0011,
    S_RTYPE_EXEC  = 4'b0100,
    S_RTYPE_COMP  = 4'b0101,
    S_MEM_REF     = 4'b0110,
    S_LW_READ     = 4'b0111,
    S_LW_COMP     = 4'b1000,
    S_SW          = 4'b1001,
    S_JAL         = 4'b1010,
    S_JR          = 4'b1011,
    S_IMM_EXEC    = 4'b1100,
    S_IMM_COMP    = 4'b1101,
    S_UNUSED_E    = 4'b1110,
    S_UNUSED_F    = 4'b1111
  } state_t;

  typedef enum logic [1:0] {
    CLS_MEM = 2'b00,
    CLS_BR  = 2'b01,
    CLS_R   = 2'b10,
    CLS_J   = 2'b11
  } alu_class_t;

  state_t     state, state_next;
  alu_class_t alu_class;
  logic       has_class;
  logic       pc_write, pc_write_cond, z;
  logic [5:0] eff_func;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = S_IF;
    IR_write      = 1'b0;
    reg_dst       = 1'b0;
    jal_reg       = 1'b0;
    pc_to_reg     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_A     = 1'b0;
    alu_src_B     = 2'b00;
    pc_src        = 2'b00;
    I_or_D        = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_class     = CLS_MEM;
    has_class     = 1'b0;
    case (state)
      S_IF: begin
        mem_read   = 1'b1;
        IR_write   = 1'b1;
        alu_src_B  = 2'b01;
        pc_write   = 1'b1;
        has_class  = 1'b1;
        state_next = S_ID;
      end
      S_ID: begin
        alu_src_B = 2'b11;
        has_class = 1'b1;
        case (opcode)
          OP_BEQ, OP_BNE:   state_next = S_BRANCH;
          OP_J:             state_next = S_JUMP;
          OP_JAL:           state_next = S_JAL;
          OP_RTYPE:         state_next = (func == FN_JR) ? S_JR : S_RTYPE_EXEC;
          OP_LW, OP_SW:     state_next = S_MEM_REF;
          OP_ADDI, OP_ANDI: state_next = S_IMM_EXEC;
          default:          state_next = S_IF;
        endcase
      end
      S_BRANCH: begin
        alu_src_A     = 1'b1;
        pc_src        = 2'b11;
        pc_write_cond = 1'b1;
        alu_class     = CLS_BR;
        has_class     = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = 2'b01;
        alu_class = CLS_J;
        has_class = 1'b1;
      end
      S_RTYPE_EXEC: begin
        alu_src_A  = 1'b1;
        alu_class  = CLS_R;
        has_class  = 1'b1;
        state_next = S_RTYPE_COMP;
      end
      S_RTYPE_COMP: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_MEM_REF: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        has_class = 1'b1;
        if (opcode == OP_LW)      state_next = S_LW_READ;
        else if (opcode == OP_SW) state_next = S_SW;
      end
      S_LW_READ: begin
        mem_read   = 1'b1;
        I_or_D     = 1'b1;
        state_next = S_LW_COMP;
      end
      S_LW_COMP: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_SW: begin
        mem_write = 1'b1;
        I_or_D    = 1'b1;
      end
      S_JAL: begin
        reg_dst   = 1'b1;
        jal_reg   = 1'b1;
        pc_to_reg = 1'b1;
        reg_write = 1'b1;
        pc_src    = 2'b01;
        pc_write  = 1'b1;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_IMM_EXEC: begin
        alu_src_A  = 1'b1;
        alu_src_B  = 2'b10;
        alu_class  = CLS_R;
        has_class  = 1'b1;
        state_next = S_IMM_COMP;
      end
      S_IMM_COMP: reg_write = 1'b1;
      default: state_next = S_IF;
    endcase
  end

  // Immediate ops reuse the R-class decode by substituting an equivalent func.
  always_comb begin
    eff_func = func;
    if (opcode == OP_ANDI)      eff_func = FN_AND;
    else if (opcode == OP_ADDI) eff_func = FN_ADD;
  end

  always_comb begin
    alu_op = ALU_ADD;
    if (has_class) begin
      case (alu_class)
        CLS_BR: alu_op = ALU_SUB;
        CLS_R: begin
          case (eff_func)
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
          endcase
        end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign z            = (opcode == OP_BNE) ? ~ZERO : ZERO;
  assign pc_cntrl_out = pc_write | (pc_write_cond & z);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: each instruction's expected
// per-cycle output bundle is derived from its kind and cycle index.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ZERO;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       pc_cntrl_out, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg;
  logic       reg_write, alu_src_A, I_or_D, mem_write, mem_read;
  logic [1:0] alu_src_B, pc_src;
  logic [2:0] alu_op;

  int passed = 0;
  int total  = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .ZERO(ZERO), .opcode(opcode), .func(func),
    .pc_cntrl_out(pc_cntrl_out), .IR_write(IR_write), .reg_dst(reg_dst),
    .jal_reg(jal_reg), .pc_to_reg(pc_to_reg), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .pc_src(pc_src), .I_or_D(I_or_D), .mem_write(mem_write),
    .mem_read(mem_read), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  typedef enum int {K_BRANCH, K_J, K_JAL, K_JR, K_R, K_LW, K_SW, K_IMM, K_ILLEGAL} kind_t;

  function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000100, 6'b000101: return K_BRANCH;
      6'b000010:            return K_J;
      6'b000011:            return K_JAL;
      6'b000000:            return (fn == 6'b001000) ? K_JR : K_R;
      6'b100011:            return K_LW;
      6'b101011:            return K_SW;
      6'b001000, 6'b001100: return K_IMM;
      default:              return K_ILLEGAL;
    endcase
  endfunction

  function automatic int latency(input logic [5:0] op, input logic [5:0] fn);
    case (kind_of(op, fn))
      K_BRANCH, K_J, K_JAL, K_JR: return 3;
      K_R, K_SW, K_IMM:           return 4;
      K_LW:                       return 5;
      default:                    return 2;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Bundle: {pcc, irw, rdst, jal, p2r, m2r, rw, srcA, srcB[2], psrc[2], iord, mw, mr, aluop[3]}
  function automatic logic [17:0] model(input logic [5:0] op, input logic [5:0] fn,
                                        input logic zr, input int step);
    logic pcc, irw, rdst, jl, p2r, m2r, rw, sa, iod, mw, mr;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    kind_t k;
    {pcc, irw, rdst, jl, p2r, m2r, rw, sa, iod, mw, mr} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b010;
    k = kind_of(op, fn);
    if (step == 0) begin
      mr = 1; irw = 1; sb = 2'b01; pcc = 1;
    end else if (step == 1) begin
      sb = 2'b11;
    end else if (step == 2) begin
      case (k)
        K_BRANCH: begin sa = 1; ps = 2'b11; ao = 3'b110; pcc = (op == 6'b000101) ? !zr : zr; end
        K_J:      begin pcc = 1; ps = 2'b01; end
        K_JAL:    begin rdst = 1; jl = 1; p2r = 1; rw = 1; ps = 2'b01; pcc = 1; end
        K_JR:     begin pcc = 1; ps = 2'b10; end
        K_R:      begin sa = 1; ao = r_alu(fn); end
        K_LW, K_SW: begin sa = 1; sb = 2'b10; end
        K_IMM:    begin sa = 1; sb = 2'b10; ao = (op == 6'b001100) ? 3'b000 : 3'b010; end
        default: ;
      endcase
    end else if (step == 3) begin
      case (k)
        K_R:   begin rdst = 1; rw = 1; end
        K_LW:  begin mr = 1; iod = 1; end
        K_SW:  begin mw = 1; iod = 1; end
        K_IMM: rw = 1;
        default: ;
      endcase
    end else if (step == 4 && k == K_LW) begin
      m2r = 1; rw = 1;
    end
    return {pcc, irw, rdst, jl, p2r, m2r, rw, sa, sb, ps, iod, mw, mr, ao};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {pc_cntrl_out, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write,
            alu_src_A, alu_src_B, pc_src, I_or_D, mem_write, mem_read, alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] exp_v;
    rst = 1'b1; ZERO = 1'b0; opcode = 6'b100011; func = 6'b000000;
    tick(); tick();
    exp_v = model(6'b100011, 6'b000000, 1'b0, 0);
    total++;
    if (dut_vec() !== exp_v)
      $display("FAIL reset_state got=%b exp=%b", dut_vec(), exp_v);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [5:0] ops[8]  = '{6'b000000, 6'b100011, 6'b000100, 6'b000100, 6'b000101, 6'b001100, 6'b000011, 6'b000000};
    logic [5:0] fns[8]  = '{6'b100010, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000};
    logic       zrs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [17:0] exp_v;
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i]; func = fns[i]; ZERO = zrs[i];
      for (int s = 0; s < latency(ops[i], fns[i]); s++) begin
        exp_v = model(ops[i], fns[i], zrs[i], s);
        total++;
        if (dut_vec() !== exp_v)
          $display("FAIL directed op=%b fn=%b z=%b step=%0d got=%b exp=%b",
                   ops[i], fns[i], zrs[i], s, dut_vec(), exp_v);
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] op_pool[10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b111111};
    logic [5:0] fn_pool[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                 6'b001000, 6'b000000};
    logic [5:0] op, fn;
    logic zr;
    logic [17:0] exp_v;
    for (int i = 0; i < 200; i++) begin
      op = op_pool[$urandom_range(0, 9)];
      if (op == 6'b111111) op = 6'($urandom_range(0, 63));
      fn = fn_pool[$urandom_range(0, 6)];
      if (fn == 6'b000000) fn = 6'($urandom_range(0, 63));
      zr = 1'($urandom_range(0, 1));
      opcode = op; func = fn; ZERO = zr;
      for (int s = 0; s < latency(op, fn); s++) begin
        exp_v = model(op, fn, zr, s);
        total++;
        if (dut_vec() !== exp_v)
          $display("FAIL random op=%b fn=%b z=%b step=%0d got=%b exp=%b",
                   op, fn, zr, s, dut_vec(), exp_v);
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_reset_mid_instruction();
    logic [17:0] exp_v;
    opcode = 6'b100011; func = 6'b000000; ZERO = 1'b0;
    tick(); tick(); tick();
    exp_v = model(6'b100011, 6'b000000, 1'b0, 3);
    total++;
    if (dut_vec() !== exp_v)
      $display("FAIL lw_read_before_reset got=%b exp=%b", dut_vec(), exp_v);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = model(6'b100011, 6'b000000, 1'b0, 0);
    total++;
    if (dut_vec() !== exp_v)
      $display("FAIL reset_mid_lw got=%b exp=%b", dut_vec(), exp_v);
    else passed++;
    tick();
    exp_v = model(6'b100011, 6'b000000, 1'b0, 1);
    total++;
    if (dut_vec() !== exp_v)
      $display("FAIL decode_after_reset got=%b exp=%b", dut_vec(), exp_v);
    else passed++;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_instruction();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- ZERO  in  1  ALU zero flag.
- opcode  in  6  instruction [31:26].
- func  in  6  instruction [5:0].
- pc_cntrl_out  out  1  PC load enable.
- IR_write  out  1  instruction register load.
- reg_dst  out  1  1 = write rd, 0 = write rt.
- jal_reg  out  1  1 = write register 31.
- pc_to_reg  out  1  1 = write PC to the register file.
- mem_to_reg  out  1  1 = write MDR, 0 = write ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_A  out  1  0 = PC, 1 = A.
- alu_src_B  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- pc_src  out  2  00 = ALU, 01 = jump target, 10 = A (jr), 11 = ALUOut.
- I_or_D  out  1  1 = data address.
- mem_write  out  1  memory write.
- mem_read  out  1  memory read.
- alu_op  out  3  ALU operation code.

Function
REQ-004 Opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000, andi 001100.
REQ-005 Func codes SHALL be: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
REQ-006 ALU operation codes SHALL be: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-007 The effective function SHALL be selected as follows:
- andi -> and.
- addi -> add.
- otherwise -> func.
REQ-008 An internal 2-bit ALU class SHALL map to alu_op combinationally:
- MEM 00 -> ADD.
- BR 01 -> SUB.
- R 10 -> decode of the effective function (add/sub/and/or/slt); unknown effective function -> ADD.
- J 11 -> ADD.
- In states without an ALU class, alu_op SHALL be ADD.
REQ-009 pc_cntrl_out SHALL equal pc_write OR (pc_write_cond AND z), combinationally.
- z = ~ZERO when opcode is bne.
- z = ZERO otherwise.
REQ-010 The FSM SHALL be a Moore machine with 4-bit state; all outputs other than alu_op and pc_cntrl_out SHALL depend on state only.
REQ-011 Every output not listed for a state SHALL be 0.
REQ-012 States and their asserted outputs SHALL be:
- IF 0000: mem_read, IR_write, alu_src_B=01, pc_write, class MEM.
- ID 0001: alu_src_B=11, class MEM.
- BRANCH 0010: alu_src_A, pc_src=11, pc_write_cond, class BR.
- JUMP 0011: pc_write, pc_src=01, class J.
- RTYPE_EXEC 0100: alu_src_A, class R.
- RTYPE_COMPLETION 0101: reg_dst, reg_write.
- MEM_REF 0110: alu_src_A, alu_src_B=10, class MEM.
- LW_READ 0111: mem_read, I_or_D.
- LW_COMPLETION 1000: mem_to_reg, reg_write.
- SW 1001: mem_write, I_or_D.
- JAL 1010: reg_dst, jal_reg, pc_to_reg, reg_write, pc_src=01, pc_write.
- JR 1011: pc_write, pc_src=10.
- IMMEDIATE_EXEC 1100: alu_src_A, alu_src_B=10, class R.
- IMMEDIATE_COMPLETION 1101: reg_write.
REQ-013 State transitions SHALL be:
- IF -> ID.
- ID -> BRANCH for beq/bne.
- ID -> JUMP for j.
- ID -> JAL for jal.
- ID -> JR for R-type with func jr.
- ID -> RTYPE_EXEC for other R-type.
- ID -> MEM_REF for lw/sw.
- ID -> IMMEDIATE_EXEC for addi/andi.
- ID -> IF for any other opcode.
REQ-014 Remaining state transitions SHALL be:
- MEM_REF -> LW_READ for lw.
- MEM_REF -> SW for sw.
- MEM_REF -> IF otherwise.
- LW_READ -> LW_COMPLETION.
- RTYPE_EXEC -> RTYPE_COMPLETION.
- IMMEDIATE_EXEC -> IMMEDIATE_COMPLETION.
- BRANCH, JUMP, JAL, JR, RTYPE_COMPLETION, LW_COMPLETION, SW, IMMEDIATE_COMPLETION -> IF.
- Unused encodings 1110 and 1111 -> IF.
REQ-015 Instruction latency SHALL be:
- 3 cycles: branch, j, jal, jr.
- 4 cycles: R-type, sw, addi, andi.
- 5 cycles: lw.

Reset
REQ-016 When rst=1 at a rising clk edge, the state SHALL become IF, overriding any transition, including mid-instruction.
REQ-017 After reset, outputs SHALL be IF values: mem_read=1, IR_write=1, alu_src_B=01, pc_cntrl_out=1, alu_op=010, all others 0.

Verification
REQ-018 Reset, then opcode=000000, func=100010 -> states IF, ID, RTYPE_EXEC (alu_op=110, alu_src_A=1), RTYPE_COMPLETION (reg_dst=1, reg_write=1), IF.
REQ-019 lw 100011 -> IF, ID, MEM_REF (alu_src_B=10, alu_op=010), LW_READ (I_or_D=1, mem_read=1), LW_COMPLETION (mem_to_reg=1, reg_write=1); 5 cycles.
REQ-020 Branch cases in BRANCH state:
- beq with ZERO=1 -> pc_cntrl_out=1, alu_op=110.
- beq with ZERO=0 -> pc_cntrl_out=0.
- bne with ZERO=0 -> pc_cntrl_out=1.
REQ-021 andi 001100 -> IMMEDIATE_EXEC with alu_op=000, then IMMEDIATE_COMPLETION with reg_write=1, reg_dst=0.
REQ-022 jal 000011 -> JAL state with jal_reg=1, pc_to_reg=1, pc_src=01, pc_cntrl_out=1.
REQ-023 jr (R-type, func 001000) -> JR state with pc_src=10, pc_cntrl_out=1.
REQ-024 rst asserted during LW_READ -> IF on the next edge.
